// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C slave mapping device 1000_a2a1a0 onto a byte memory with an auto-incrementing pointer
module i2c_slave_ctrl #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic              a2,
    input  logic              a1,
    input  logic              a0,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV_ADDR  = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] WORD_ADDR = 4'd3;
    localparam logic [3:0] WA_ACK    = 4'd4;
    localparam logic [3:0] WR_DATA   = 4'd5;
    localparam logic [3:0] WR_ACK    = 4'd6;
    localparam logic [3:0] RD_LOAD   = 4'd7;
    localparam logic [3:0] RD_DATA   = 4'd8;
    localparam logic [3:0] RD_ACK    = 4'd9;
    logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic [3:0] state;
    logic [2:0] cnt;
    logic [7:0] shreg;
    logic [7:0] byte_in;
    logic [MEM_AW-1:0] ptr;
    logic rw, mack;
    logic scl_rise, scl_fall, start, stop, addr_hit;
    always_comb begin
        scl_rise = scl_s2 & ~scl_d;
        scl_fall = ~scl_s2 & scl_d;
        start    = scl_s2 & sda_d & ~sda_s2;
        stop     = scl_s2 & ~sda_d & sda_s2;
        byte_in  = {shreg[6:0], sda_s2};
        addr_hit = byte_in[7:1] == {4'b1000, a2, a1, a0};
    end
    assign mem_addr = ptr;
    assign busy     = state != IDLE;
    // Sync flops come out of reset at the idle-bus level so no edge is seen on release
    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {scl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            cnt       <= 3'd0;
            shreg     <= 8'h00;
            rw        <= 1'b0;
            mack      <= 1'b0;
            ptr       <= '0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we)
                ptr <= ptr + 1'b1;
            if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
            end else if (start) begin
                state  <= DEV_ADDR;
                cnt    <= 3'd0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    DEV_ADDR, WORD_ADDR, WR_DATA: if (scl_rise) begin
                        shreg <= byte_in;
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (state == DEV_ADDR) begin
                                state <= addr_hit ? DEV_ACK : IDLE;
                                rw    <= addr_hit ? byte_in[0] : rw;
                            end else if (state == WORD_ADDR) begin
                                ptr   <= MEM_AW'(byte_in);
                                state <= WA_ACK;
                            end else begin
                                mem_wdata <= byte_in;
                                mem_we    <= 1'b1;
                                state     <= WR_ACK;
                            end
                        end
                    end
                    // First scl fall drives the ACK, the second one ends the 9th clock
                    DEV_ACK, WA_ACK, WR_ACK: if (scl_fall) begin
                        sda_oe <= ~sda_oe;
                        if (sda_oe) begin
                            cnt   <= 3'd0;
                            state <= state == DEV_ACK ? (rw ? RD_LOAD : WORD_ADDR) : WR_DATA;
                        end
                    end
                    RD_LOAD: begin
                        shreg  <= mem_rdata;
                        sda_oe <= ~mem_rdata[7];
                        state  <= RD_DATA;
                    end
                    // cnt wraps to 0 on the 8th rise, so a fall with cnt 0 closes the byte
                    RD_DATA: if (scl_rise) begin
                        cnt   <= cnt + 3'd1;
                        shreg <= {shreg[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_oe <= 1'b0;
                            ptr    <= ptr + 1'b1;
                            state  <= RD_ACK;
                        end else
                            sda_oe <= ~shreg[7];
                    end
                    RD_ACK: if (scl_rise)
                        mack <= sda_s2;
                    else if (scl_fall) begin
                        cnt   <= 3'd0;
                        state <= mack ? IDLE : RD_LOAD;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
